seven_seg_scan_decoder: RTL and testbench

- Inverse of the board's multiplexed 7-segment display driver: watches the `segments`/`anodos` pins of a scanning display and reconstructs the 8-digit hex value shown.
- Synthesizable. Used in-fabric as a loopback checker of the display path, and in benches as a scoreboard source for counter/debouncer designs.
- Publishes a complete frame only after every digit has been sampled during a stable window.

---
 rtl/seven_seg_pkg.sv | 52 +++++
 rtl/seven_seg_scan_decoder_decode.sv | 50 +++++
 rtl/seven_seg_scan_decoder.sv | 206 ++++++++++++++++++++
 tb/tb_seven_seg_scan_decoder.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_pkg
// Description : Shared constants and types for the 7-segment scan decoder.
//               Segment patterns are active-high {a,b,c,d,e,f,g}, a = MSB.
// Revision    : 1.0 - initial release
// ============================================================================
package seven_seg_pkg;

    localparam int N_DIGITS = 8;

    localparam logic [6:0] SEG_0     = 7'h7E;
    localparam logic [6:0] SEG_1     = 7'h30;
    localparam logic [6:0] SEG_2     = 7'h6D;
    localparam logic [6:0] SEG_3     = 7'h79;
    localparam logic [6:0] SEG_4     = 7'h33;
    localparam logic [6:0] SEG_5     = 7'h5B;
    localparam logic [6:0] SEG_6     = 7'h5F;
    localparam logic [6:0] SEG_7     = 7'h70;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h7B;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h1F;
    localparam logic [6:0] SEG_C     = 7'h4E;
    localparam logic [6:0] SEG_D     = 7'h3D;
    localparam logic [6:0] SEG_E     = 7'h4F;
    localparam logic [6:0] SEG_F     = 7'h47;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SETTLE = 2'd1,
        HELD   = 2'd2
    } state_t;

    // True when exactly one anode is active.
    function automatic logic is_onehot(input logic [N_DIGITS-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

    // Index of the active anode; only meaningful when is_onehot() holds.
    function automatic logic [2:0] onehot_index(input logic [N_DIGITS-1:0] v);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seven_seg_scan_decoder_decode.sv
`default_nettype none
// ============================================================================
// Module      : seg7_pattern_decode
// Description : Purely combinational 7-segment pattern to hex nibble decoder.
// Ports       : i_pattern [6:0] active-high {a..g}
//               o_nibble  [3:0] decoded hex value (0 for blank/illegal)
//               o_legal         pattern is one of the 16 hex glyphs
//               o_blank         pattern is all segments off
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_pattern_decode
    import seven_seg_pkg::*;
(
    input  logic [6:0] i_pattern,
    output logic [3:0] o_nibble,
    output logic       o_legal,
    output logic       o_blank
);

    always_comb begin
        o_nibble = 4'h0;
        o_legal  = 1'b1;
        o_blank  = 1'b0;
        case (i_pattern)
            SEG_0:     o_nibble = 4'h0;
            SEG_1:     o_nibble = 4'h1;
            SEG_2:     o_nibble = 4'h2;
            SEG_3:     o_nibble = 4'h3;
            SEG_4:     o_nibble = 4'h4;
            SEG_5:     o_nibble = 4'h5;
            SEG_6:     o_nibble = 4'h6;
            SEG_7:     o_nibble = 4'h7;
            SEG_8:     o_nibble = 4'h8;
            SEG_9:     o_nibble = 4'h9;
            SEG_A:     o_nibble = 4'hA;
            SEG_B:     o_nibble = 4'hB;
            SEG_C:     o_nibble = 4'hC;
            SEG_D:     o_nibble = 4'hD;
            SEG_E:     o_nibble = 4'hE;
            SEG_F:     o_nibble = 4'hF;
            SEG_BLANK: begin
                o_legal = 1'b0;
                o_blank = 1'b1;
            end
            default:   o_legal = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seven_seg_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_scan_decoder
// Description : Watches the pins of a multiplexed 8-digit 7-segment display
//               and reconstructs the hex value being shown. A frame is
//               published only after all eight digits were sampled while
//               their anode/segment inputs were stable.
// Ports       : clock, reset      system clock, synchronous active-high reset
//               segments [6:0]    {CA..CG}, active-low
//               anodos   [7:0]    {AN7..AN0}, active-low
//               value    [31:0]   last good frame, nibble i = digit on AN i
//               blank_mask [7:0]  digits that were blank in last good frame
//               frame_valid       1-cycle pulse, value/blank_mask updated
//               frame_error       1-cycle pulse, frame had an illegal glyph
//               scan_timeout      level, no frame completed in time
// Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_scan_decoder
    import seven_seg_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [6:0]  segments,
    input  logic [7:0]  anodos,
    output logic [31:0] value,
    output logic [7:0]  blank_mask,
    output logic        frame_valid,
    output logic        frame_error,
    output logic        scan_timeout
);

    localparam logic [7:0]  c_SETTLE     = 8'(SETTLE_CYCLES);
    localparam logic [20:0] c_TIMEOUT    = 21'(TIMEOUT_CYCLES);
    localparam logic [20:0] c_TIMEOUT_M1 = 21'(TIMEOUT_CYCLES - 1);

    // Input stage (active-high copies) and their previous-cycle values
    logic [6:0]  r_seg;
    logic [7:0]  r_an;
    logic [6:0]  r_seg_prev;
    logic [7:0]  r_an_prev;

    logic [7:0]  r_stable;
    logic [20:0] r_to_cnt;
    state_t      r_state;
    state_t      w_state_next;

    logic [31:0] r_shadow;
    logic [7:0]  r_shadow_blank;
    logic [7:0]  r_seen;
    logic        r_bad;

    logic [31:0] r_value;
    logic [7:0]  r_blank_mask;
    logic        r_frame_valid;
    logic        r_frame_error;
    logic        r_scan_timeout;

    logic        w_seg_changed;
    logic        w_an_changed;
    logic        w_an_onehot;
    logic [2:0]  w_idx;
    logic        w_capture;
    logic        w_complete;
    logic        w_timeout_hit;
    logic [3:0]  w_dec_nibble;
    logic        w_dec_legal;
    logic        w_dec_blank;

    assign w_seg_changed = (r_seg != r_seg_prev);
    assign w_an_changed  = (r_an != r_an_prev);
    assign w_an_onehot   = is_onehot(r_an);
    assign w_idx         = onehot_index(r_an);
    assign w_complete    = (r_seen == 8'hFF);
    // Fires once, on the cycle the counter reaches its limit
    assign w_timeout_hit = (r_to_cnt == c_TIMEOUT_M1);

    seg7_pattern_decode u_decode (
        .i_pattern (r_seg),
        .o_nibble  (w_dec_nibble),
        .o_legal   (w_dec_legal),
        .o_blank   (w_dec_blank)
    );

    // ------------------------------------------------------------------
    // Input registers and stability counter
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_seg      <= '0;
            r_an       <= '0;
            r_seg_prev <= '0;
            r_an_prev  <= '0;
            r_stable   <= '0;
        end else begin
            r_seg      <= ~segments;
            r_an       <= ~anodos;
            r_seg_prev <= r_seg;
            r_an_prev  <= r_an;
            if (w_seg_changed || w_an_changed) begin
                r_stable <= '0;
            end else if (r_stable != c_SETTLE) begin
                r_stable <= r_stable + 8'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Digit sampling FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= HUNT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        case (r_state)
            HUNT: begin
                if (w_an_onehot) w_state_next = SETTLE;
            end
            SETTLE: begin
                if (!w_an_onehot || w_an_changed) begin
                    w_state_next = HUNT;
                end else if ((r_stable == c_SETTLE) && !w_seg_changed) begin
                    // The counter lags the inputs by a cycle; the extra
                    // seg-change guard keeps a just-changed glyph from
                    // being sampled on a stale count.
                    w_capture    = 1'b1;
                    w_state_next = HELD;
                end
            end
            HELD: begin
                if (w_an_changed) w_state_next = HUNT;
            end
            default: w_state_next = HUNT;
        endcase
    end

    // ------------------------------------------------------------------
    // Shadow frame, completion and timeout
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_shadow       <= '0;
            r_shadow_blank <= '0;
            r_seen         <= '0;
            r_bad          <= 1'b0;
            r_to_cnt       <= '0;
            r_value        <= '0;
            r_blank_mask   <= 8'hFF;
            r_frame_valid  <= 1'b0;
            r_frame_error  <= 1'b0;
            r_scan_timeout <= 1'b0;
        end else begin
            r_frame_valid <= 1'b0;
            r_frame_error <= 1'b0;

            if (w_capture) begin
                r_shadow[4*w_idx +: 4] <= w_dec_legal ? w_dec_nibble : 4'h0;
                r_shadow_blank[w_idx]  <= w_dec_blank;
            end

            if (w_complete) begin
                // Completion outranks a coincident timeout
                r_seen   <= '0;
                r_bad    <= 1'b0;
                r_to_cnt <= '0;
                if (!r_bad) begin
                    r_value        <= r_shadow;
                    r_blank_mask   <= r_shadow_blank;
                    r_frame_valid  <= 1'b1;
                    r_scan_timeout <= 1'b0;
                end else begin
                    r_frame_error  <= 1'b1;
                end
            end else begin
                if (r_to_cnt != c_TIMEOUT) begin
                    r_to_cnt <= r_to_cnt + 21'd1;
                end
                if (w_timeout_hit) begin
                    r_scan_timeout <= 1'b1;
                    r_seen         <= '0;
                    r_bad          <= 1'b0;
                end else if (w_capture) begin
                    r_seen[w_idx] <= 1'b1;
                    if (!w_dec_legal && !w_dec_blank) r_bad <= 1'b1;
                end
            end
        end
    end

    assign value        = r_value;
    assign blank_mask   = r_blank_mask;
    assign frame_valid  = r_frame_valid;
    assign frame_error  = r_frame_error;
    assign scan_timeout = r_scan_timeout;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_seven_seg_scan_decoder
// Description : Directed self-checking bench for seven_seg_scan_decoder.
//               Expected frames are queued as each scan is driven and
//               popped when the decoder pulses frame_valid/frame_error.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seven_seg_scan_decoder;

    logic        clock;
    logic        reset;
    logic [6:0]  segments;
    logic [7:0]  anodos;
    logic [31:0] value;
    logic [7:0]  blank_mask;
    logic        frame_valid;
    logic        frame_error;
    logic        scan_timeout;

    seven_seg_scan_decoder #(
        .SETTLE_CYCLES  (4),
        .TIMEOUT_CYCLES (1024)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .segments     (segments),
        .anodos       (anodos),
        .value        (value),
        .blank_mask   (blank_mask),
        .frame_valid  (frame_valid),
        .frame_error  (frame_error),
        .scan_timeout (scan_timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  kind;   // {frame_valid, frame_error}
        logic [31:0] val;
        logic [7:0]  blank;
    } exp_t;

    exp_t        q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          last_pulse_cyc = 0;
    int          rise_cyc;

    logic [6:0]  segt [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                               7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic show(input int k, input logic [6:0] pat, input int n);
        anodos   = ~(8'd1 << k);
        segments = ~pat;
        repeat (n) tick();
    endtask

    task automatic gap(input int n);
        anodos   = 8'hFF;
        segments = 7'h7F;
        repeat (n) tick();
    endtask

    task automatic scan_frame(input logic [31:0] v, input int dwell);
        for (int k = 7; k >= 0; k--) show(k, segt[v[4*k +: 4]], dwell);
    endtask

    task automatic expect_frame(input logic [1:0] kind, input logic [31:0] v, input logic [7:0] b);
        exp_t e;
        e.kind  = kind;
        e.val   = v;
        e.blank = b;
        q.push_back(e);
    endtask

    // Scoreboard consumer
    always @(negedge clock) begin
        if (frame_valid === 1'b1 || frame_error === 1'b1) begin
            last_pulse_cyc = cyc;
            if (q.size() == 0) begin
                check("unexpected_pulse", {30'd0, frame_valid, frame_error}, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("pulse_kind", {30'd0, frame_valid, frame_error}, {30'd0, e.kind});
                check("frame_value", value, e.val);
                check("frame_blank", {24'd0, blank_mask}, {24'd0, e.blank});
                if (frame_valid) check("timeout_low_at_valid", {31'd0, scan_timeout}, 32'd0);
            end
        end
    end

    initial begin
        reset    = 1'b1;
        segments = 7'h7F;
        anodos   = 8'hFF;
        repeat (3) tick();

        // Reset state
        check("rst_value", value, 32'd0);
        check("rst_blank", {24'd0, blank_mask}, 32'h0000_00FF);
        check("rst_fv", {31'd0, frame_valid}, 32'd0);
        check("rst_fe", {31'd0, frame_error}, 32'd0);
        check("rst_to", {31'd0, scan_timeout}, 32'd0);
        reset = 1'b0;
        tick();

        // Clean scan
        expect_frame(2'b10, 32'h1234ABCD, 8'h00);
        scan_frame(32'h1234ABCD, 10);
        gap(4);
        check("clean_value", value, 32'h1234ABCD);

        // Settling: short "5" dwell on AN3 must not be sampled
        expect_frame(2'b10, 32'h01236789, 8'h00);
        show(7, segt[0], 10);
        show(6, segt[1], 10);
        show(5, segt[2], 10);
        show(4, segt[3], 10);
        show(3, segt[5], 3);
        show(3, segt[6], 8);
        show(2, segt[7], 10);
        show(1, segt[8], 10);
        show(0, segt[9], 10);
        gap(4);

        // Illegal glyph on AN2, then a clean frame of zeros
        expect_frame(2'b01, 32'h01236789, 8'h00);
        for (int k = 7; k >= 0; k--) show(k, (k == 2) ? 7'h01 : segt[0], 10);
        gap(4);
        check("err_value_held", value, 32'h01236789);
        expect_frame(2'b10, 32'h0000_0000, 8'h00);
        scan_frame(32'h0, 10);
        gap(4);

        // Blank upper digits with dark gaps between digits
        expect_frame(2'b10, 32'h00009876, 8'hF0);
        for (int k = 7; k >= 4; k--) begin
            show(k, 7'h00, 10);
            gap(2);
        end
        show(3, segt[9], 10); gap(2);
        show(2, segt[8], 10); gap(2);
        show(1, segt[7], 10); gap(2);
        show(0, segt[6], 10); gap(2);
        check("blank_mask_after", {24'd0, blank_mask}, 32'h0000_00F0);

        // Timeout: five digits then silence
        for (int k = 7; k >= 3; k--) show(k, segt[k], 10);
        gap(1);
        rise_cyc = -1;
        for (int i = 0; i < 2000; i++) begin
            if (scan_timeout === 1'b1) begin
                rise_cyc = cyc;
                break;
            end
            tick();
        end
        check("timeout_asserted", {31'd0, scan_timeout}, 32'd1);
        check("timeout_latency", 32'(rise_cyc - last_pulse_cyc), 32'd1024);

        // Recovery: full rescan, timeout holds until the valid pulse
        expect_frame(2'b10, 32'hFEDCBA98, 8'h00);
        for (int k = 7; k >= 1; k--) show(k, segt[8 + k], 10);
        check("timeout_held_mid_scan", {31'd0, scan_timeout}, 32'd1);
        show(0, segt[8], 10);
        gap(4);
        check("timeout_cleared", {31'd0, scan_timeout}, 32'd0);

        // Reset mid-frame
        for (int k = 7; k >= 2; k--) show(k, segt[k + 1], 10);
        gap(1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_value", value, 32'd0);
        check("midrst_blank", {24'd0, blank_mask}, 32'h0000_00FF);
        check("midrst_to", {31'd0, scan_timeout}, 32'd0);
        show(1, segt[2], 10);
        show(0, segt[1], 10);
        gap(20);
        check("partial_no_update", value, 32'd0);
        expect_frame(2'b10, 32'h87654321, 8'h00);
        scan_frame(32'h87654321, 10);
        gap(6);

        check("queue_drained", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
